b_syn_up_mod: RTL and testbench

- Synchronous modulo-N up counter; the counting-up counterpart of the team's 4-bit synchronous down counter.
- Adds programmable terminal value, parallel load, count enable and carry-in/carry-out for cascading into multi-digit counters.
- Adds a sticky overflow flag and a saturating wrap-event counter.
- Used as a timebase and event counter in lab designs, e.g. two instances cascaded for a 00–99 BCD counter.

---
 rtl/b_syn_up_mod.sv | 122 ++++++++++++
 tb/tb_b_syn_up_mod.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/b_syn_up_mod.sv
// b_syn_up_mod
// Synchronous modulo-N up counter with programmable terminal value, parallel
// load, count enable and carry-in/carry-out for cascading. It also has a sticky
// overflow flag and a saturating wrap-event counter.
//
// Ports:
//   clk      in   clock; all state updates on its rising edge
//   re       in   synchronous active-high reset (highest priority)
//   en       in   count enable
//   ci       in   carry-in; a count step needs en=1 and ci=1
//   ld       in   parallel load strobe (beats counting)
//   d        in   WIDTH-bit parallel load value
//   mod_max  in   WIDTH-bit terminal count; the counter wraps to 0 after it
//   clr_ovf  in   clears the sticky overflow flag (a coincident wrap wins)
//   c        out  registered count value
//   co       out  combinational carry-out; high in the cycle before a wrap edge
//   ovf      out  registered sticky overflow flag
//   wraps    out  registered saturating count of wrap events
module b_syn_up_mod #(
  parameter int WIDTH = 4,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             re,
  input  logic             en,
  input  logic             ci,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] mod_max,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] c,
  output logic             co,
  output logic             ovf,
  output logic [WRAPW-1:0] wraps
);

  localparam logic [WIDTH-1:0] C_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1'b1);
  localparam logic [WRAPW-1:0] W_ZERO   = {WRAPW{1'b0}};
  localparam logic [WRAPW-1:0] W_ONE    = WRAPW'(1'b1);
  localparam logic [WRAPW-1:0] W_MAX    = {WRAPW{1'b1}};

  // Power-up values match the reset values.
  logic [WIDTH-1:0] c_q     = {WIDTH{1'b0}};
  logic             ovf_q   = 1'b0;
  logic [WRAPW-1:0] wraps_q = {WRAPW{1'b0}};

  logic [WIDTH-1:0] c_d;
  logic             ovf_d;
  logic [WRAPW-1:0] wraps_d;
  logic             step_s;
  logic             at_top_s;
  logic             wrap_s;

  // Step qualification and wrap detection; co is the wrap condition itself.
  always_comb begin
    step_s   = en & ci & ~ld & ~re;
    // >= (not ==) so an out-of-range loaded value also wraps on its next step.
    at_top_s = (c_q >= mod_max);
    wrap_s   = step_s & at_top_s;
  end

  // Next-state for the count value: load beats counting, otherwise hold.
  always_comb begin
    c_d = c_q;
    if (ld) begin
      c_d = d;
    end else if (step_s) begin
      if (at_top_s) begin
        c_d = C_ZERO;
      end else begin
        c_d = c_q + C_ONE;
      end
    end else begin
      c_d = c_q;
    end
  end

  // Next-state for the sticky flag: a wrap sets it even if clr_ovf is high.
  always_comb begin
    ovf_d = ovf_q;
    if (wrap_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Next-state for the wrap counter: saturates instead of rolling over.
  always_comb begin
    wraps_d = wraps_q;
    if (wrap_s && (wraps_q != W_MAX)) begin
      wraps_d = wraps_q + W_ONE;
    end else begin
      wraps_d = wraps_q;
    end
  end

  // State registers with synchronous reset overriding load, count and flags.
  always_ff @(posedge clk) begin
    if (re) begin
      c_q     <= C_ZERO;
      ovf_q   <= 1'b0;
      wraps_q <= W_ZERO;
    end else begin
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      wraps_q <= wraps_d;
    end
  end

  // Output drive: co stays combinational so cascaded stages step on the same edge.
  always_comb begin
    c     = c_q;
    ovf   = ovf_q;
    wraps = wraps_q;
    co    = wrap_s;
  end

endmodule

// File: tb/tb_b_syn_up_mod.sv
// Self-checking bench for b_syn_up_mod: a shared-stimulus pair (WRAPW=8 and
// WRAPW=2) checked every cycle against an integer model, plus a two-digit
// cascade checked against a 0..99 decimal model, plus literal spot checks.
module tb_b_syn_up_mod;

  logic       clk = 1'b0;
  logic       re = 1'b1, en = 1'b0, ci = 1'b0, ld = 1'b0, clr_ovf = 1'b0;
  logic [3:0] d = 4'd0, mod_max = 4'd9;
  logic [3:0] c8, c2;
  logic       co8, co2, ovf8, ovf2;
  logic [7:0] w8;
  logic [1:0] w2;

  logic       cre = 1'b1, cen = 1'b0;
  logic [3:0] uc, tc;
  logic       uco, tco, uovf, tovf;
  logic [7:0] uw, tw;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model of the shared-stimulus pair
  int m_c = 0;
  bit m_ovf = 1'b0;
  int m_w8 = 0;
  int m_w2 = 0;
  // model of the cascade: a plain decimal value 0..99
  int cv = 0;
  bit c_uovf = 1'b0, c_tovf = 1'b0;
  int c_uw = 0, c_tw = 0;

  always #5 clk = ~clk;

  b_syn_up_mod #(.WIDTH(4), .WRAPW(8)) dut8 (
    .clk(clk), .re(re), .en(en), .ci(ci), .ld(ld), .d(d), .mod_max(mod_max),
    .clr_ovf(clr_ovf), .c(c8), .co(co8), .ovf(ovf8), .wraps(w8));

  b_syn_up_mod #(.WIDTH(4), .WRAPW(2)) dut2 (
    .clk(clk), .re(re), .en(en), .ci(ci), .ld(ld), .d(d), .mod_max(mod_max),
    .clr_ovf(clr_ovf), .c(c2), .co(co2), .ovf(ovf2), .wraps(w2));

  b_syn_up_mod #(.WIDTH(4), .WRAPW(8)) units (
    .clk(clk), .re(cre), .en(cen), .ci(1'b1), .ld(1'b0), .d(4'd0), .mod_max(4'd9),
    .clr_ovf(1'b0), .c(uc), .co(uco), .ovf(uovf), .wraps(uw));

  b_syn_up_mod #(.WIDTH(4), .WRAPW(8)) tens (
    .clk(clk), .re(cre), .en(cen), .ci(uco), .ld(1'b0), .d(4'd0), .mod_max(4'd9),
    .clr_ovf(1'b0), .c(tc), .co(tco), .ovf(tovf), .wraps(tw));

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Main model: plain rules re > ld > count > hold, counted with integers.
  always @(posedge clk) begin
    if (re) begin
      m_c <= 0; m_ovf <= 1'b0; m_w8 <= 0; m_w2 <= 0;
    end else if (ld) begin
      m_c <= int'(d);
      if (clr_ovf) m_ovf <= 1'b0;
    end else if (en && ci && (m_c >= int'(mod_max))) begin
      m_c <= 0; m_ovf <= 1'b1;
      m_w8 <= (m_w8 < 255) ? m_w8 + 1 : 255;
      m_w2 <= (m_w2 < 3) ? m_w2 + 1 : 3;
    end else if (en && ci) begin
      m_c <= m_c + 1;
      if (clr_ovf) m_ovf <= 1'b0;
    end else if (clr_ovf) begin
      m_ovf <= 1'b0;
    end
  end

  // Cascade model: one decimal number that advances by one per enabled edge.
  always @(posedge clk) begin
    if (cre) begin
      cv <= 0; c_uovf <= 1'b0; c_tovf <= 1'b0; c_uw <= 0; c_tw <= 0;
    end else if (cen) begin
      cv <= (cv + 1) % 100;
      if (cv % 10 == 9) begin c_uovf <= 1'b1; c_uw <= c_uw + 1; end
      if (cv == 99) begin c_tovf <= 1'b1; c_tw <= c_tw + 1; end
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("c8", int'(c8), m_c);
      chk("c2", int'(c2), m_c);
      chk("co8", int'(co8), int'(en && ci && !ld && !re && (m_c >= int'(mod_max))));
      chk("co2", int'(co2), int'(en && ci && !ld && !re && (m_c >= int'(mod_max))));
      chk("ovf8", int'(ovf8), int'(m_ovf));
      chk("ovf2", int'(ovf2), int'(m_ovf));
      chk("wraps8", int'(w8), m_w8);
      chk("wraps2", int'(w2), m_w2);
      chk("units_c", int'(uc), cv % 10);
      chk("tens_c", int'(tc), cv / 10);
      chk("units_co", int'(uco), int'(cen && !cre && (cv % 10 == 9)));
      chk("tens_co", int'(tco), int'(cen && !cre && (cv == 99)));
      chk("units_ovf", int'(uovf), int'(c_uovf));
      chk("tens_ovf", int'(tovf), int'(c_tovf));
      chk("units_wraps", int'(uw), c_uw);
      chk("tens_wraps", int'(tw), c_tw);
    end
  end

  initial begin
    // reset
    step(1);
    chk_en = 1'b1;
    chk("rst_c", int'(c8), 0);
    chk("rst_ovf", int'(ovf8), 0);
    chk("rst_wraps", int'(w8), 0);

    // 1: count 0..9,0,1 with mod_max=9
    re = 1'b0; en = 1'b1; ci = 1'b1; mod_max = 4'd9;
    step(11);
    chk("t1_c", int'(c8), 1);
    chk("t1_ovf", int'(ovf8), 1);
    chk("t1_wraps", int'(w8), 1);
    chk("t1_model_c", m_c, 1);

    // 2: load beats count; out-of-range value wraps on the next step
    ld = 1'b1; d = 4'd3;
    step(1);
    chk("t2_c3", int'(c8), 3);
    d = 4'd7;
    step(1);
    chk("t2_c7", int'(c8), 7);
    ld = 1'b0; mod_max = 4'd5;
    #1;
    chk("t2_co_oor", int'(co8), 1);
    step(1);
    chk("t2_c0", int'(c8), 0);
    chk("t2_wraps", int'(w8), 2);
    chk("t2_model_w", m_w8, 2);

    // 4: enable/carry gating
    ld = 1'b1; d = 4'd4;
    step(1);
    ld = 1'b0; ci = 1'b0;
    step(5);
    chk("t4_ci0_c", int'(c8), 4);
    chk("t4_ci0_co", int'(co8), 0);
    en = 1'b0; ci = 1'b1;
    step(3);
    chk("t4_en0_c", int'(c8), 4);

    // 5: wrap and clr_ovf on the same edge, set wins
    mod_max = 4'd2; ld = 1'b1; d = 4'd2; clr_ovf = 1'b1;
    step(1);
    chk("t5_ld_clr_ovf", int'(ovf8), 0);
    ld = 1'b0; en = 1'b1;
    step(1);
    chk("t5_race_c", int'(c8), 0);
    chk("t5_race_ovf", int'(ovf8), 1);
    en = 1'b0;
    step(1);
    chk("t5_clr_ovf", int'(ovf8), 0);
    clr_ovf = 1'b0;

    // 6: mod_max=0, saturation, then reset together with a load
    mod_max = 4'd0; en = 1'b1;
    step(6);
    chk("t6_c", int'(c8), 0);
    chk("t6_w2_sat", int'(w2), 3);
    chk("t6_w8", int'(w8), 9);
    chk("t6_model_w2", m_w2, 3);
    re = 1'b1; ld = 1'b1; d = 4'd5;
    #1;
    chk("t6_co_in_re", int'(co8), 0);
    step(1);
    chk("t6_re_c", int'(c8), 0);
    chk("t6_re_w8", int'(w8), 0);
    chk("t6_re_w2", int'(w2), 0);
    chk("t6_re_ovf", int'(ovf8), 0);

    // mod_max all ones: plain modulo-16
    re = 1'b0; ld = 1'b0; mod_max = 4'd15;
    step(15);
    chk("m16_c15", int'(c8), 15);
    step(1);
    chk("m16_c0", int'(c8), 0);
    chk("m16_wraps", int'(w8), 1);
    en = 1'b0;

    // 3: cascade 00..99..00
    cre = 1'b0; cen = 1'b1;
    step(99);
    chk("t3_units99", int'(uc), 9);
    chk("t3_tens99", int'(tc), 9);
    chk("t3_tens_co", int'(tco), 1);
    step(1);
    chk("t3_units0", int'(uc), 0);
    chk("t3_tens0", int'(tc), 0);
    chk("t3_tens_ovf", int'(tovf), 1);
    chk("t3_units_wraps", int'(uw), 10);
    chk("t3_model_v", cv, 0);
    cen = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
